// File: rtl/if_fetch.sv
// Instruction-fetch stage.
// Owns the fetch PC and issues one word read at a time to the instruction
// memory, predicting PC+4 (static not-taken). Returned words are handed to
// decode through an output register (O) backed by a one-entry skid buffer (S).
// A redirect from EX flushes O and S and restarts fetch at the new target.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc_next
);

  // IDLE: nothing outstanding. BUSY: live request outstanding.
  // DISCARD: request outstanding whose data is stale after a redirect.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        imem_read_q, imem_read_d;
  logic [31:0] imem_addr_q, imem_addr_d;

  // Output register O
  logic        o_valid_q, o_valid_d;
  logic [31:0] o_pc_q, o_pc_d;
  logic [31:0] o_instr_q, o_instr_d;
  logic [31:0] o_pc_next_q, o_pc_next_d;

  // Skid buffer S (always older than any response arriving alongside it)
  logic        s_valid_q, s_valid_d;
  logic [31:0] s_pc_q, s_pc_d;
  logic [31:0] s_instr_q, s_instr_d;

  logic [31:0] target_pc;
  logic        accept;
  logic        drain;
  logic        o_free;

  // Word-align the redirect target; the low two bits carry no meaning.
  assign target_pc = redirect_pc & ~32'h0000_0003;

  // A response is only live in BUSY and is dropped when a redirect coincides.
  assign accept = (state_q == BUSY) && imem_resp && !redirect;
  assign drain  = o_valid_q && id_ready;
  assign o_free = !o_valid_q || drain;

  // Output register / skid buffer steering: redirect flushes both; otherwise
  // O refills from S first, then from an accepted response.
  always_comb begin
    // NOTE: every signal written in this block gets its hold value first so
    // no path through the if/else tree leaves it unassigned (no latch).
    o_valid_d   = o_valid_q;
    o_pc_d      = o_pc_q;
    o_instr_d   = o_instr_q;
    o_pc_next_d = o_pc_next_q;
    s_valid_d   = s_valid_q;
    s_pc_d      = s_pc_q;
    s_instr_d   = s_instr_q;

    if (redirect) begin
      o_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (o_free) begin
      if (s_valid_q) begin
        o_valid_d   = 1'b1;
        o_pc_d      = s_pc_q;
        o_instr_d   = s_instr_q;
        o_pc_next_d = s_pc_q + 32'd4;
        // S moves into O, so a same-edge response can take S's place.
        s_valid_d   = accept;
        if (accept) begin
          s_pc_d    = imem_addr_q;
          s_instr_d = imem_rdata;
        end
      end else if (accept) begin
        o_valid_d   = 1'b1;
        o_pc_d      = imem_addr_q;
        o_instr_d   = imem_rdata;
        o_pc_next_d = imem_addr_q + 32'd4;
      end else begin
        o_valid_d = 1'b0;
      end
    end else if (accept) begin
      // O is full and stalled: park the response in S.
      s_valid_d = 1'b1;
      s_pc_d    = imem_addr_q;
      s_instr_d = imem_rdata;
    end
  end

  // Request FSM: issues a new request only when S will have room for its data.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    imem_read_d = imem_read_q;
    imem_addr_d = imem_addr_q;

    if (redirect) begin
      fetch_pc_d = target_pc;
    end

    case (state_q)
      IDLE: begin
        if (!s_valid_d) begin
          imem_read_d = 1'b1;
          imem_addr_d = fetch_pc_d;
          state_d     = BUSY;
        end else begin
          imem_read_d = 1'b0;
        end
      end
      BUSY: begin
        if (imem_resp) begin
          if (redirect) begin
            // Response dropped; restart at the target without leaving BUSY.
            imem_addr_d = target_pc;
          end else begin
            fetch_pc_d = imem_addr_q + 32'd4;
            if (!s_valid_d) begin
              imem_addr_d = imem_addr_q + 32'd4;
            end else begin
              imem_read_d = 1'b0;
              state_d     = IDLE;
            end
          end
        end else if (redirect) begin
          // The in-flight request cannot be cancelled; wait it out.
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_resp) begin
          imem_addr_d = fetch_pc_d;
          state_d     = BUSY;
        end
      end
      default: begin
        imem_read_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // FSM and request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      imem_read_q <= 1'b0;
      imem_addr_q <= 32'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_read_q <= imem_read_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  // Output register and skid buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the data fields are reset too, because if_pc/if_instruction are
      // visible outputs with defined reset values (and S is only 2 words).
      o_valid_q   <= 1'b0;
      o_pc_q      <= 32'h0;
      o_instr_q   <= 32'h0;
      o_pc_next_q <= 32'h4;
      s_valid_q   <= 1'b0;
      s_pc_q      <= 32'h0;
      s_instr_q   <= 32'h0;
    end else begin
      o_valid_q   <= o_valid_d;
      o_pc_q      <= o_pc_d;
      o_instr_q   <= o_instr_d;
      o_pc_next_q <= o_pc_next_d;
      s_valid_q   <= s_valid_d;
      s_pc_q      <= s_pc_d;
      s_instr_q   <= s_instr_d;
    end
  end

  assign imem_read      = imem_read_q;
  assign imem_addr      = imem_addr_q;
  assign if_valid       = o_valid_q;
  assign if_pc          = o_pc_q;
  assign if_instruction = o_instr_q;
  assign if_pc_next     = o_pc_next_q;

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: a behavioural instruction memory with programmable
// latency, a stream scoreboard that tracks the expected PC sequence from the
// redirect/reset history, and directed scenario tasks plus a random run.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0060;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic        imem_resp = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic [31:0] if_pc_next;

  int n_checks = 0;
  int n_fail = 0;
  int n_consumed = 0;
  int mem_latency = 1;

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_addr(imem_addr),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .if_valid(if_valid), .if_pc(if_pc),
    .if_instruction(if_instruction), .if_pc_next(if_pc_next)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the word address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  // Memory: sees a request at posedge+1, answers mem_latency cycles later
  // (latency 1 = answer in the same cycle the request is first visible).
  logic        mem_pending = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst !== 1'b1) begin
        mem_pending = 1'b0;
        imem_resp   = 1'b0;
      end else begin
        if (imem_resp) begin
          imem_resp   = 1'b0;
          mem_pending = 1'b0;
        end
        if (mem_pending) begin
          n_checks++;
          if (imem_read !== 1'b1 || imem_addr !== mem_addr) begin
            n_fail++;
            $display("FAIL imem_hold: read=%b addr=%h, need read=1 addr=%h", imem_read, imem_addr, mem_addr);
          end
        end else if (imem_read === 1'b1) begin
          mem_pending = 1'b1;
          mem_addr    = imem_addr;
          mem_cnt     = mem_latency;
          n_checks++;
          if (imem_addr[1:0] !== 2'b00) begin
            n_fail++;
            $display("FAIL imem_align: addr=%h, need low bits 00", imem_addr);
          end
        end
        if (mem_pending) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            imem_resp  = 1'b1;
            imem_rdata = instr_of(mem_addr);
          end
        end
      end
    end
  end

  // Stream scoreboard: every handshake with decode must deliver the next PC
  // of the architectural stream (reset PC, +4 steps, restart at redirects).
  logic [31:0] exp_pc = RESET_PC;
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        exp_pc = RESET_PC;
      end else if (redirect) begin
        exp_pc = redirect_pc & ~32'h3;
      end else if (if_valid === 1'b1 && id_ready) begin
        n_checks++;
        if (if_pc !== exp_pc) begin
          n_fail++;
          $display("FAIL stream_pc: got %h expected %h", if_pc, exp_pc);
        end
        n_checks++;
        if (if_instruction !== instr_of(exp_pc)) begin
          n_fail++;
          $display("FAIL stream_instr: got %h expected %h", if_instruction, instr_of(exp_pc));
        end
        n_checks++;
        if (if_pc_next !== exp_pc + 32'd4) begin
          n_fail++;
          $display("FAIL stream_pc_next: got %h expected %h", if_pc_next, exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
        n_consumed++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    id_ready = 1'b1;
    mem_latency = 1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (imem_read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b expected 0", imem_read); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
    n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", if_pc); end
    n_checks++; if (if_instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", if_instruction); end
    rst = 1'b1;
    tick();
    n_checks++; if (imem_read !== 1'b1) begin n_fail++; $display("FAIL first_req_read: got %b expected 1", imem_read); end
    n_checks++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL first_req_addr: got %h expected %h", imem_addr, RESET_PC); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL first_req_valid: got %b expected 0", if_valid); end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] want;
      tick();
      want = RESET_PC + 32'(4 * i);
      n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL stream%0d_valid: got %b expected 1", i, if_valid); end
      n_checks++; if (if_pc !== want) begin n_fail++; $display("FAIL stream%0d_pc: got %h expected %h", i, if_pc, want); end
      n_checks++; if (if_pc_next !== want + 32'd4) begin n_fail++; $display("FAIL stream%0d_pc_next: got %h expected %h", i, if_pc_next, want + 32'd4); end
    end
  endtask

  task automatic test_backpressure();
    id_ready = 1'b0;
    mem_latency = 1;
    do_reset();
    repeat (4) tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h60) begin n_fail++; $display("FAIL bp_hold: valid=%b pc=%h expected 1/00000060", if_valid, if_pc); end
    n_checks++; if (imem_read !== 1'b0) begin n_fail++; $display("FAIL bp_read_drop: got %b expected 0", imem_read); end
    repeat (3) tick();
    n_checks++; if (if_pc !== 32'h60 || imem_read !== 1'b0) begin n_fail++; $display("FAIL bp_stable: pc=%h read=%b expected 00000060/0", if_pc, imem_read); end
    id_ready = 1'b1;
    tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h64) begin n_fail++; $display("FAIL bp_skid_out: valid=%b pc=%h expected 1/00000064", if_valid, if_pc); end
    n_checks++; if (imem_read !== 1'b1 || imem_addr !== 32'h68) begin n_fail++; $display("FAIL bp_resume_req: read=%b addr=%h expected 1/00000068", imem_read, imem_addr); end
    tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h68) begin n_fail++; $display("FAIL bp_resume_out: valid=%b pc=%h expected 1/00000068", if_valid, if_pc); end
    tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h6C) begin n_fail++; $display("FAIL bp_resume_next: valid=%b pc=%h expected 1/0000006c", if_valid, if_pc); end
  endtask

  task automatic test_discard();
    logic found;
    int waited;
    id_ready = 1'b1;
    mem_latency = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (imem_read === 1'b1 && imem_addr === 32'h70) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL discard_find_req: request to 00000070 not seen, got addr %h", imem_addr); end
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    n_checks++; if (imem_read !== 1'b1 || imem_addr !== 32'h70) begin n_fail++; $display("FAIL discard_hold: read=%b addr=%h expected 1/00000070", imem_read, imem_addr); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL discard_flush: valid=%b expected 0", if_valid); end
    tick();
    n_checks++; if (imem_read !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL discard_new_req: read=%b addr=%h expected 1/00000200", imem_read, imem_addr); end
    waited = 0;
    while (if_valid !== 1'b1 && waited < 10) begin
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL discard_idle_valid: valid=%b expected 0", if_valid); end
      tick();
      waited++;
    end
    n_checks++; if (waited != 3) begin n_fail++; $display("FAIL discard_latency: waited %0d cycles expected 3", waited); end
    n_checks++; if (if_pc !== 32'h200) begin n_fail++; $display("FAIL discard_first_pc: got %h expected 00000200", if_pc); end
  endtask

  task automatic test_redirect_with_resp();
    logic found;
    int waited;
    id_ready = 1'b1;
    mem_latency = 2;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      tick();
      if (imem_resp === 1'b1 && imem_addr === 32'h80) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rr_find_resp: response for 00000080 not seen, got addr %h", imem_addr); end
    redirect = 1'b1;
    redirect_pc = 32'h1003;
    tick();
    redirect = 1'b0;
    n_checks++; if (imem_read !== 1'b1 || imem_addr !== 32'h1000) begin n_fail++; $display("FAIL rr_new_req: read=%b addr=%h expected 1/00001000", imem_read, imem_addr); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rr_flush: valid=%b expected 0", if_valid); end
    waited = 0;
    while (if_valid !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h1000) begin n_fail++; $display("FAIL rr_first_pc: valid=%b pc=%h expected 1/00001000", if_valid, if_pc); end
  endtask

  task automatic test_redirect_full();
    id_ready = 1'b0;
    mem_latency = 1;
    do_reset();
    repeat (5) tick();
    n_checks++; if (if_valid !== 1'b1 || imem_read !== 1'b0) begin n_fail++; $display("FAIL rf_full: valid=%b read=%b expected 1/0", if_valid, imem_read); end
    id_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rf_flush: valid=%b expected 0", if_valid); end
    n_checks++; if (imem_read !== 1'b1 || imem_addr !== 32'h300) begin n_fail++; $display("FAIL rf_req: read=%b addr=%h expected 1/00000300", imem_read, imem_addr); end
    tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h300) begin n_fail++; $display("FAIL rf_first_pc: valid=%b pc=%h expected 1/00000300", if_valid, if_pc); end
  endtask

  task automatic test_wrap();
    int waited;
    id_ready = 1'b1;
    mem_latency = 1;
    do_reset();
    repeat (3) tick();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    waited = 0;
    while (if_valid !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top_pc: valid=%b pc=%h expected 1/fffffffc", if_valid, if_pc); end
    n_checks++; if (if_pc_next !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_next: got %h expected 00000000", if_pc_next); end
    tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_zero_pc: valid=%b pc=%h expected 1/00000000", if_valid, if_pc); end
  endtask

  task automatic test_reset_mid();
    id_ready = 1'b1;
    mem_latency = 3;
    do_reset();
    repeat (4) tick();
    n_checks++; if (imem_read !== 1'b1 || if_valid !== 1'b1) begin n_fail++; $display("FAIL rm_busy: read=%b valid=%b expected 1/1", imem_read, if_valid); end
    rst = 1'b0;
    #1;
    n_checks++; if (imem_read !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL rm_async: read=%b valid=%b expected 0/0", imem_read, if_valid); end
    n_checks++; if (imem_addr !== 32'h0 || if_pc !== 32'h0) begin n_fail++; $display("FAIL rm_async_regs: addr=%h pc=%h expected 0/0", imem_addr, if_pc); end
  endtask

  task automatic test_random();
    int start;
    id_ready = 1'b1;
    mem_latency = 1;
    do_reset();
    start = n_consumed;
    for (int i = 0; i < 3000; i++) begin
      tick();
      id_ready    = ($urandom_range(0, 3) != 0);
      mem_latency = int'($urandom_range(1, 4));
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
    end
    tick();
    redirect = 1'b0;
    repeat (10) tick();
    n_checks++; if (n_consumed - start < 200) begin n_fail++; $display("FAIL random_progress: consumed %0d expected at least 200", n_consumed - start); end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_discard();
    test_redirect_with_resp();
    test_redirect_full();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
